// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the regfile_mp register file.
//   ERR_WR_ZERO / ERR_WB_NOT_BUSY : bit positions inside err_code
//   DEF_DATA_W / DEF_ADDR_W       : default datapath geometry
//   port_addr()                   : pulls read port i's address out of the packed bus
package regfile_pkg;

  localparam int ERR_WR_ZERO     = 0;
  localparam int ERR_WB_NOT_BUSY = 1;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Widest address bus the helper handles (4 ports x 8-bit addresses).
  localparam int MAX_RD = 4;
  localparam int MAX_AW = 8;
  localparam int BUS_W  = MAX_RD * MAX_AW;

  // Port i occupies bits [i*aw +: aw]; upper result bits are zero.
  function automatic logic [MAX_AW-1:0] port_addr(input logic [BUS_W-1:0] bus,
                                                  input int i, input int aw);
    logic [BUS_W-1:0]  sh;
    logic [MAX_AW-1:0] r;
    sh = bus >> (i * aw);
    for (int b = 0; b < MAX_AW; b++) r[b] = (b < aw) ? sh[b] : 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// rf_scoreboard: per-register busy bits for in-flight producers.
//   issue (iss_valid/iss_addr) sets busy, writeback (wr_en/wr_addr) clears it;
//   a same-cycle write+issue to one register leaves it busy (new producer).
//   Outputs: rd_busy per read port, iss_stall on WAW, wb_not_busy flags a
//   writeback that found its destination idle (feeds the error logic).
module rf_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_stall,
  output logic                     wb_not_busy
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             wr_ok, iss_req, iss_ok, wr_hits_iss;
  logic [BUS_W-1:0] addr_bus;

  assign wr_ok       = en & wr_en & (wr_addr != '0);
  assign iss_req     = en & iss_valid & (iss_addr != '0);
  assign wr_hits_iss = wr_ok & (wr_addr == iss_addr);
  // A writeback retiring the old producer frees the slot for this issue.
  assign iss_ok      = iss_req & (~busy_q[iss_addr] | wr_hits_iss);
  assign iss_stall   = iss_req & ~iss_ok;
  assign wb_not_busy = wr_ok & ~busy_q[wr_addr] & ~(iss_req & wr_hits_iss);

  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[wr_addr]  = 1'b0;
    if (iss_ok) busy_d[iss_addr] = 1'b1;  // issue wins over same-cycle clear
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;

  assign addr_bus = BUS_W'(rd_addr);

  for (genvar i = 0; i < NUM_RD; i++) begin : g_lk
    logic [ADDR_W-1:0] a;
    assign a = ADDR_W'(port_addr(addr_bus, i, ADDR_W));
    assign rd_busy[i] = (a != '0) & busy_q[a] &
                        ~(BYPASS & en & wr_en & (wr_addr == a));
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NUM_RD-read / 1-write register file, r0 reads zero.
//   rd_addr/rd_data/rd_busy : combinational read ports (optional write bypass)
//   wr_en/wr_addr/wr_data   : writeback port
//   iss_valid/iss_addr      : issue marks destination busy; iss_stall on WAW
//   err_clr/err/err_code    : sticky error causes (r0 write, idle writeback)
//   en low freezes all state and disables bypass and stall.
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_stall,
  input  logic                     err_clr,
  output logic                     err,
  output logic [1:0]               err_code
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [1:0]        err_code_q, err_code_d, new_err;
  logic              wr_ok, wb_not_busy;
  logic [BUS_W-1:0]  addr_bus;

  rf_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .BYPASS(BYPASS)) u_sb (
    .clk(clk), .reset(reset), .en(en), .rd_addr(rd_addr), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_stall(iss_stall), .wb_not_busy(wb_not_busy)
  );

  assign wr_ok = en & wr_en & (wr_addr != '0);

  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    else if (wr_ok) mem_q[wr_addr] <= wr_data;

  assign addr_bus = BUS_W'(rd_addr);

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = ADDR_W'(port_addr(addr_bus, i, ADDR_W));
    assign rd_data[i*DATA_W +: DATA_W] =
      (a == '0)                                      ? '0      :
      (BYPASS && en && wr_en && (wr_addr == a))      ? wr_data :
                                                       mem_q[a];
  end

  always_comb begin
    new_err                  = '0;
    new_err[ERR_WR_ZERO]     = en & wr_en & (wr_addr == '0);
    new_err[ERR_WB_NOT_BUSY] = wb_not_busy;
    err_code_d               = err_code_q;
    // Clear drops old causes but keeps anything raised this cycle.
    if (en) err_code_d = err_clr ? new_err : (err_code_q | new_err);
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) err_code_q <= '0;
    else        err_code_q <= err_code_d;

  assign err_code = err_code_q;
  assign err      = |err_code_q;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0, wr_en = 1'b0, iss_valid = 1'b0, err_clr = 1'b0;
  logic [4:0]  wr_addr = '0, iss_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  ra [3];

  logic [9:0]  rd_addr_a;
  logic [14:0] rd_addr_b;
  logic [63:0] rd_data_a;
  logic [95:0] rd_data_b;
  logic [1:0]  rd_busy_a, errc_a, errc_b;
  logic [2:0]  rd_busy_b;
  logic        stall_a, stall_b, err_a, err_b;

  int nvec = 0, nerr = 0;

  // reference state
  logic [31:0] m_mem  [32];
  logic        m_busy [32];
  logic [1:0]  m_errc;

  always #5 clk = ~clk;

  assign rd_addr_a = {ra[1], ra[0]};
  assign rd_addr_b = {ra[2], ra[1], ra[0]};

  regfile_mp dut_a (
    .clk(clk), .reset(reset), .en(en), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_stall(stall_a),
    .err_clr(err_clr), .err(err_a), .err_code(errc_a));

  regfile_mp #(.NUM_RD(3), .BYPASS(1'b0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_stall(stall_b),
    .err_clr(err_clr), .err(err_b), .err_code(errc_b));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic fwd(input logic [4:0] a, input bit byp);
    return byp && en && wr_en && (wr_addr == a);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0)      return 32'h0;
    if (fwd(a, byp)) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (a == 0 || fwd(a, byp)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_stall();
    return en && iss_valid && iss_addr != 0 && m_busy[iss_addr] &&
           !(wr_en && wr_addr == iss_addr);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin m_mem[k] = '0; m_busy[k] = 1'b0; end
    m_errc = 2'b00;
  endtask

  // Apply one clock edge's worth of spec rules to the reference.
  task automatic model_step();
    logic [1:0] ne;
    logic       st;
    if (!en) return;
    ne = 2'b00;
    st = exp_stall();
    if (wr_en) begin
      if (wr_addr == 0) ne[0] = 1'b1;
      else begin
        if (!m_busy[wr_addr] && !(iss_valid && iss_addr == wr_addr)) ne[1] = 1'b1;
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
    end
    if (iss_valid && iss_addr != 0 && !st) m_busy[iss_addr] = 1'b1;
    m_errc = err_clr ? ne : (m_errc | ne);
  endtask

  task automatic check_all();
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rdA%0d", p), 64'(rd_data_a[p*32 +: 32]), 64'(exp_rd(ra[p], 1'b1)));
      chk($sformatf("busyA%0d", p), 64'(rd_busy_a[p]), 64'(exp_busy(ra[p], 1'b1)));
    end
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("rdB%0d", p), 64'(rd_data_b[p*32 +: 32]), 64'(exp_rd(ra[p], 1'b0)));
      chk($sformatf("busyB%0d", p), 64'(rd_busy_b[p]), 64'(exp_busy(ra[p], 1'b0)));
    end
    chk("stallA", 64'(stall_a), 64'(exp_stall()));
    chk("stallB", 64'(stall_b), 64'(exp_stall()));
    chk("errcA", 64'(errc_a), 64'(m_errc));
    chk("errcB", 64'(errc_b), 64'(m_errc));
    chk("errA", 64'(err_a), 64'(|m_errc));
    chk("errB", 64'(err_b), 64'(|m_errc));
  endtask

  task automatic cyc(input logic e, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic iv, input logic [4:0] ia,
                     input logic ec, input logic [4:0] a0, input logic [4:0] a1,
                     input logic [4:0] a2);
    @(negedge clk);
    en = e; wr_en = we; wr_addr = wa; wr_data = wd;
    iss_valid = iv; iss_addr = ia; err_clr = ec;
    ra[0] = a0; ra[1] = a1; ra[2] = a2;
    #1 check_all();
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, a0, a1, a2);
  endtask

  initial begin
    model_reset();
    ra[0] = '0; ra[1] = '0; ra[2] = '0;
    #12 reset = 1'b1;

    // read every address after reset
    for (int k = 0; k < 32; k++) idle(5'(k), 5'(31 - k), 5'(k));

    // reset asserted in the middle of a write to r5
    @(negedge clk);
    en = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; ra[0] = 5'd5;
    #2 reset = 1'b0; wr_en = 1'b0;
    model_reset();
    #1 chk("rst_r5", 64'(rd_data_a[31:0]), 64'h0);
    chk("rst_errA", 64'(err_a), 64'h0);
    @(negedge clk) reset = 1'b1;
    idle(5'd5, 5'd5, 5'd5);

    // issue r7, then writeback with bypass
    cyc(1, 0, 0, 0, 1, 7, 0, 7, 0, 7);
    idle(7, 7, 7);
    cyc(1, 1, 7, 32'h1234, 0, 0, 0, 7, 7, 7);
    idle(7, 7, 7);

    // WAW stall on r3, then same-cycle write+issue
    cyc(1, 0, 0, 0, 1, 3, 0, 3, 0, 3);
    cyc(1, 0, 0, 0, 1, 3, 0, 3, 0, 3);
    cyc(1, 1, 3, 32'h3333_0003, 1, 3, 0, 3, 3, 3);
    idle(3, 3, 3);

    // error paths
    cyc(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 9, 32'h0000_0909, 0, 0, 0, 9, 0, 9);
    idle(9, 0, 9);
    cyc(1, 1, 0, 32'h1, 0, 0, 1, 0, 0, 0);
    idle(0, 0, 0);

    // frozen when en=0
    cyc(0, 1, 4, 32'h4444_4444, 1, 4, 1, 4, 4, 4);
    idle(4, 4, 4);

    // no bypass on dut_b: all three ports see old then new r2
    cyc(1, 1, 2, 32'hA5A5A5A5, 0, 0, 0, 2, 2, 2);
    idle(2, 2, 2);

    // randomized traffic, addresses biased toward a small window
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] wa, ia, a0, a1, a2;
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ia = 5'($urandom_range(0, 7));
      a0 = 5'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 7));
      a2 = 5'($urandom_range(0, 31));
      cyc(($urandom_range(0, 9) != 0), 1'($urandom), wa, $urandom,
          1'($urandom), ia, ($urandom_range(0, 15) == 0), a0, a1, a2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with write-through bypass, a per-register busy scoreboard, and sticky error reporting. It is the next-generation general-purpose register file for the MIPS datapath. It serves NUM_RD decode-stage read ports and one writeback port, and tells the hazard unit which source registers still wait on an in-flight producer. Register 0 is hard-wired to zero.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return the stored value

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-low
- en  in  1  global enable; low freezes registers, scoreboard and error state
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  scoreboard busy bit per read address, combinational
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  DATA_W  writeback data
- iss_valid  in  1  instruction issue marking a destination busy
- iss_addr  in  ADDR_W  issue destination
- iss_stall  out  1  issue refused, destination already busy (WAW), combinational
- err_clr  in  1  clears sticky error state
- err  out  1  sticky error flag
- err_code  out  2  sticky cause bits: [0] write to r0, [1] writeback to a non-busy register

## Operation
- Reset values: all registers 0, all busy bits 0, err 0, err_code 00. rd_data follows from register contents (all 0); iss_stall 0 unless busy is set.
- Read: rd_data[i] = 0 if rd_addr[i]==0. Else, if BYPASS and en and wr_en and wr_addr==rd_addr[i], it is wr_data. Else it is the stored register.
- rd_busy[i] = busy[rd_addr[i]], except as follows:
  - forced 0 when BYPASS and a qualifying write to that address occurs this cycle.
  - always 0 for r0.
- Write (en=1, wr_en=1, wr_addr≠0): the register takes wr_data at the edge and busy[wr_addr] is cleared. If busy was already 0, err_code[1] is set and the write still commits.
- Write to r0: data discarded, err_code[0] set.
- Issue (en=1, iss_valid=1, iss_addr≠0):
  - if busy[iss_addr]==0 or a write to iss_addr occurs this cycle: busy[iss_addr] set at the edge, iss_stall 0.
  - otherwise iss_stall=1 and the scoreboard is unchanged.
- Issue to r0: ignored, no busy, no error, no stall.
- Same-cycle write and issue to one address: data commits, busy ends 1 (new producer owns it), no error.
- err = |err_code. Error bits accumulate (OR) until err_clr.
- err_clr and a new error in the same cycle: the new error's bit is set and the other bits cleared.
- en=0: no register, busy or error update. Reads and rd_busy stay live. Bypass is disabled. iss_stall reports 0.

## Timing
- Reads and rd_busy: zero latency (combinational from addresses and state).
- Write: visible in storage one rising edge after wr_en. With BYPASS it is visible on rd_data in the same cycle.
- Issue → rd_busy high on the next cycle. Write → rd_busy low on the next cycle, or the same cycle with BYPASS.
- Error bits: set on the edge that samples the offending write; err rises on that edge.
- Asynchronous reset mid-operation clears all state immediately, regardless of clk/en. Deassertion is synchronised externally.

## Structure
- Package regfile_pkg holds:
  - ERR_WR_ZERO=0, ERR_WB_NOT_BUSY=1 bit indices;
  - the default DATA_W/ADDR_W constants;
  - a function extracting port i's address slice.
- Sub-module rf_scoreboard (ADDR_W) owns:
  - the busy vector;
  - issue/clear/stall logic;
  - the busy lookups, NUM_RD parametrised.
- Top level holds storage, bypass muxes and error logic.

## Test plan
- Reset, then read all 32 addresses on both ports → all 0, rd_busy 00, err 0. Assert reset mid-write of 0xDEADBEEF to r5 → r5 reads 0.
- Issue r7, next cycle rd_addr0=7 → rd_busy[0]=1. Write r7=0x1234 → same-cycle rd_data0=0x1234 and rd_busy[0]=0 (BYPASS=1). Next cycle stored value 0x1234, busy 0.
- Issue r3 twice on consecutive cycles → second cycle iss_stall=1 and busy unchanged. Same-cycle write r3 plus issue r3 → iss_stall=0, r3 updated, busy stays 1.
- Write r0=0xFFFFFFFF → rd_data 0, err=1, err_code=01. Write non-busy r9 → err_code=11 and r9 written. err_clr together with a write to r0 → err_code=01.
- en=0 with wr_en to r4 and iss_valid to r4 → r4 unchanged, busy 0, no error, rd_data shows the stored value.
- BYPASS=0, NUM_RD=3 build: write r2=0xA5A5A5A5 read simultaneously on all ports → old value that cycle, new value next cycle.
